// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mul_pkg: shared FSM encoding, defaults and operand-pair type.   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package mul_pkg;

  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_pair_t;

endpackage
`default_nettype wire

// File: rtl/mul_dispatch_op_fifo.sv
`default_nettype none
// +----------------------------------------------------------------+
// | op_fifo: power-of-two operand-pair FIFO with combinational head.|
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module op_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  op_pair_t push_data,
  input  logic     pop,
  output op_pair_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  op_pair_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mul_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mul_dispatch: feeds queued operand pairs to a shift-add mult.   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        mul_clr,
  output logic        mul_run,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_ans,
  input  logic        mul_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_prod,
  output logic        res_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    mul_a_q, mul_a_d;
  logic [7:0]    mul_b_q, mul_b_d;
  logic [15:0]   res_prod_q, res_prod_d;
  logic          res_err_q, res_err_d;
  logic          mul_clr_q, mul_clr_d;
  logic          mul_run_q, mul_run_d;
  logic          res_valid_q, res_valid_d;

  op_pair_t fifo_wdata;
  op_pair_t fifo_rdata;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;

  // Held low while reset is asserted so nothing is accepted into a clearing FIFO.
  assign in_ready     = rst && !fifo_full;
  assign fifo_push    = in_valid && in_ready;
  assign fifo_wdata.a = in_a;
  assign fifo_wdata.b = in_b;

  op_fifo #(
    .DEPTH(DEPTH)
  ) u_op_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_wdata),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    res_prod_d = res_prod_q;
    res_err_d  = res_err_q;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CLR;
        end
      end
      ST_CLR: begin
        tmo_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // Completion is checked first so it wins on the final allowed cycle.
        if (mul_done) begin
          res_prod_d = mul_ans;
          res_err_d  = 1'b0;
          state_d    = ST_HOLD;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          res_prod_d = '0;
          res_err_d  = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_CLR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fifo_pop) begin
      mul_a_d = fifo_rdata.a;
      mul_b_d = fifo_rdata.b;
    end

    mul_clr_d   = (state_d == ST_CLR);
    mul_run_d   = (state_d == ST_RUN);
    res_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_prod_q  <= '0;
      res_err_q   <= 1'b0;
      mul_clr_q   <= 1'b0;
      mul_run_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_prod_q  <= res_prod_d;
      res_err_q   <= res_err_d;
      mul_clr_q   <= mul_clr_d;
      mul_run_q   <= mul_run_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign mul_clr   = mul_clr_q;
  assign mul_run   = mul_run_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;
  assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mul_dispatch: directed bench with shift-add multiplier model.|
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_mul_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_clr;
  logic        mul_run;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_ans;
  logic        mul_done;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_prod;
  logic        res_err;

  typedef struct packed {
    logic [15:0] prod;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   clr_cnt     = 0;
  int   t0;
  int   seen;
  logic stuck       = 1'b0;
  logic b2b_mode    = 1'b0;
  logic expect_clr  = 1'b0;

  mul_dispatch dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .mul_clr  (mul_clr),
    .mul_run  (mul_run),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_ans  (mul_ans),
    .mul_done (mul_done),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_prod (res_prod),
    .res_err  (res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (mul_clr) clr_cnt = clr_cnt + 1;

  // Shift-add multiplier: one multiplier bit per run cycle, done after 8.
  logic [15:0] m_acc, m_cand;
  logic [7:0]  m_plier;
  logic [3:0]  m_cnt;
  logic        m_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc <= '0; m_cand <= '0; m_plier <= '0; m_cnt <= '0; m_done <= 1'b0;
    end else if (mul_clr) begin
      m_acc <= '0; m_cand <= {8'd0, mul_a}; m_plier <= mul_b; m_cnt <= '0; m_done <= 1'b0;
    end else if (mul_run && !m_done) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_cnt   <= m_cnt + 4'd1;
      if (m_cnt == 4'd7) m_done <= 1'b1;
    end
  end

  assign mul_ans  = m_acc;
  assign mul_done = m_done && !stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return mul_clr;
      1:       return mul_run;
      default: return res_valid;
    endcase
  endfunction

  task automatic wait_high(input int which, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!probe(which) && n < 100);
    check(tag, 32'(probe(which)), 32'd1);
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the pair is accepted.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit keep);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("push_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (keep) begin
      if (stuck) exp_q.push_back(exp_t'{16'd0, 1'b1});
      else       exp_q.push_back(exp_t'{16'(a) * 16'(b), 1'b0});
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (expect_clr) begin
      check("b2b_no_idle_gap", 32'(mul_clr), 32'd1);
      expect_clr = 1'b0;
    end
    if (rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'(res_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_prod", 32'(res_prod), 32'(mon_e.prod));
        check("res_err", 32'(res_err), 32'(mon_e.err));
        if (b2b_mode && exp_q.size() != 0) expect_clr = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mul_clr", 32'(mul_clr), 32'd0);
    check("rst_mul_run", 32'(mul_run), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_prod", 32'(res_prod), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single job: one clear pulse, 2 + 8 cycle latency, product 30.
    res_ready = 1'b1;
    push(8'd5, 8'd6, 1'b1);
    wait_high(0, "single_clr");
    t0 = cyc;
    check("clr_run_low", 32'(mul_run), 32'd0);
    @(negedge clk);
    check("clr_one_cycle", 32'(mul_clr), 32'd0);
    check("run_high", 32'(mul_run), 32'd1);
    check("run_mul_a", 32'(mul_a), 32'd5);
    check("run_mul_b", 32'(mul_b), 32'd6);
    wait_high(2, "single_valid");
    check("single_latency", 32'(cyc - t0), 32'd10);
    @(posedge clk); #1;
    wait_drain("drain_single");
    check("single_clr_pulses", 32'(clr_cnt), 32'd1);

    // Back-to-back jobs with no idle gap.
    b2b_mode = 1'b1;
    push(8'd2, 8'd22, 1'b1);
    push(8'd32, 8'd32, 1'b1);
    push(8'd21, 8'd21, 1'b1);
    push(8'd9, 8'd0, 1'b1);
    wait_drain("drain_b2b");
    b2b_mode = 1'b0;

    // Backpressure: one job held, four more fill the FIFO.
    res_ready = 1'b0;
    push(8'd1, 8'd3, 1'b1);
    wait_high(2, "bp_first_valid");
    @(posedge clk); #1;
    push(8'd10, 8'd10, 1'b1);
    push(8'd255, 8'd255, 1'b1);
    push(8'd0, 8'd7, 1'b1);
    push(8'd128, 8'd2, 1'b1);
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99;
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    repeat (3) begin
      check("bp_prod_stable", 32'(res_prod), 32'd3);
      check("bp_valid_held", 32'(res_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0; res_ready = 1'b1;
    wait_drain("drain_bp");
    check("bp_in_ready_restored", 32'(in_ready), 32'd1);

    // Timeout with mul_done stuck low, then a normal job.
    res_ready = 1'b0;
    stuck = 1'b1;
    push(8'd3, 8'd4, 1'b1);
    wait_high(1, "to_run");
    t0 = cyc;
    wait_high(2, "to_valid");
    check("to_run_cycles", 32'(cyc - t0), 32'd24);
    check("to_err", 32'(res_err), 32'd1);
    check("to_prod", 32'(res_prod), 32'd0);
    @(posedge clk); #1 stuck = 1'b0; res_ready = 1'b1;
    wait_drain("drain_to");
    push(8'd7, 8'd8, 1'b1);
    wait_drain("drain_after_to");

    // Reset in the middle of a run with another pair queued.
    push(8'd7, 8'd7, 1'b0);
    push(8'd2, 8'd3, 1'b0);
    wait_high(1, "rst_run");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mul_run", 32'(mul_run), 32'd0);
    check("mid_rst_mul_clr", 32'(mul_clr), 32'd0);
    check("mid_rst_mul_a", 32'(mul_a), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res_prod", 32'(res_prod), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid || mul_clr || mul_run) seen++;
    end
    check("no_activity_after_reset", 32'(seen), 32'd0);
    @(posedge clk); #1;
    push(8'd4, 8'd5, 1'b1);
    wait_drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
